mux2_rr_arbiter: RTL

Round-robin, packet-locked arbiter that shares a single 2:1 output path between two valid/ready requesters (A and B). It decides which requester owns the mux select, holds that grant for a whole packet (until the `last` beat), and drives the selected beat into a one-deep registered output stage. It sits in front of any downstream consumer that two producers must share.

---
 rtl/mux2_arb_pkg.sv | 15 +
 rtl/mux2_out_slice.sv | 47 ++++
 rtl/mux2_rr_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg
//   Shared definitions for the two-requester packet-locked round-robin arbiter:
//   the arbitration state type and the mux select encodings.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_out_slice.sv
// mux2_out_slice
//   One-deep registered output stage. Holds a single beat and presents it
//   downstream until it is taken.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : capture load_data/load_last this cycle
//   load_data   : payload to capture
//   load_last   : end-of-packet flag to capture
//   y_ready     : downstream accepts the held beat
//   y_valid     : a beat is held
//   y_data      : held payload
//   y_last      : held end-of-packet flag
//   space       : the stage can take a new beat this cycle
module mux2_out_slice #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              y_ready,
    output logic              y_valid,
    output logic [DATA_W-1:0] y_data,
    output logic              y_last,
    output logic              space
);

    // Empty, or the held beat leaves this cycle.
    assign space = !y_valid || y_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            y_last  <= 1'b0;
        end else if (load) begin
            // A load while draining simply replaces the outgoing beat.
            y_valid <= 1'b1;
            y_data  <= load_data;
            y_last  <= load_last;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
//   Shares one output path between requesters A and B. A grant is held for a
//   whole packet (until the beat with last=1 is accepted); ties in IDLE are
//   broken by a round-robin priority flop that flips to the other side after
//   every packet.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   a_valid/a_data/a_last/a_ready : requester A valid/ready channel
//   b_valid/b_data/b_last/b_ready : requester B valid/ready channel
//   y_valid/y_data/y_last/y_ready : shared output channel (registered)
//   sel                         : 0 = A, 1 = B; meaningful while busy
//   busy                        : a packet grant is held
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_ready,
    output logic              y_valid,
    output logic [DATA_W-1:0] y_data,
    output logic              y_last,
    input  logic              y_ready,
    output logic              sel,
    output logic              busy
);

    arb_state_t        state;
    logic              prio;
    logic              space;
    logic              a_take;
    logic              b_take;
    logic              load;
    logic [DATA_W-1:0] mux_data;
    logic              mux_last;

    // Readies depend only on state and the output register, never on valids.
    assign a_ready = (state == GRANT_A) && space;
    assign b_ready = (state == GRANT_B) && space;
    assign a_take  = a_valid && a_ready;
    assign b_take  = b_valid && b_ready;
    assign load    = a_take || b_take;

    always_comb begin
        mux_data = a_data;
        mux_last = a_last;
        if (sel == SEL_B) begin
            mux_data = b_data;
            mux_last = b_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prio  <= SEL_A;
            sel   <= SEL_A;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (a_valid && (!b_valid || prio == SEL_A)) begin
                        state <= GRANT_A;
                        sel   <= SEL_A;
                        busy  <= 1'b1;
                    end else if (b_valid) begin
                        state <= GRANT_B;
                        sel   <= SEL_B;
                        busy  <= 1'b1;
                    end
                end
                GRANT_A: begin
                    if (a_take && a_last) begin
                        state <= IDLE;
                        prio  <= SEL_B;
                        sel   <= SEL_A;
                        busy  <= 1'b0;
                    end
                end
                GRANT_B: begin
                    if (b_take && b_last) begin
                        state <= IDLE;
                        prio  <= SEL_A;
                        sel   <= SEL_A;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    sel   <= SEL_A;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    mux2_out_slice #(
        .DATA_W(DATA_W)
    ) u_out_slice (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (mux_data),
        .load_last (mux_last),
        .y_ready   (y_ready),
        .y_valid   (y_valid),
        .y_data    (y_data),
        .y_last    (y_last),
        .space     (space)
    );

endmodule
